// File: rtl/uart_pkg.sv
// Shared constants for the uart ALU sequencer: FSM encodings, default widths, opcodes.
package uart_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned OP_WIDTH_DEF   = 6;

    // Sequencer state encodings
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT_B  = 3'd1;
    localparam logic [2:0] S_WAIT_OP = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_SEND    = 3'd4;
    localparam logic [2:0] S_WAIT_TX = 3'd5;

    // ALU opcodes understood by the datapath
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout counter: clears on request, counts while enabled, flags terminal count.
module uart_frame_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter int unsigned TO_W           = 21
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc_c
);

    localparam logic [TO_W-1:0] TC_VAL = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] count;

    // Counter saturates at terminal count; the controller leaves the wait state there anyway
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != TC_VAL)) begin
            count <= count + TO_W'(1);
        end
    end

    // Terminal count is only meaningful while the wait states are counting
    always_comb begin
        tc_c = enable && (count == TC_VAL);
    end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Collects A, B, opcode from the uart receiver, runs the ALU and sends the result back.
module uart_alu_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned OP_WIDTH       = OP_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter int unsigned TO_W           = 21
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_rx_done,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_tx_done,
    output logic                  o_tx_start,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    output logic [OP_WIDTH-1:0]   o_alu_op,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    output logic                  o_busy,
    output logic                  o_timeout,
    output logic                  o_overrun
);

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [DATA_WIDTH-1:0] a_nxt;
    logic [DATA_WIDTH-1:0] b_nxt;
    logic [OP_WIDTH-1:0]   op_nxt;
    logic [DATA_WIDTH-1:0] tx_data_nxt;
    logic                  tx_start_nxt;
    logic                  busy_nxt;
    logic                  timeout_nxt;
    logic                  overrun_nxt;
    logic                  timer_clear;
    logic                  timer_enable;
    logic                  timer_tc_c;

    // Timer restarts on every state change and every received byte
    assign timer_clear  = (state_nxt != state) || i_rx_done;
    assign timer_enable = (state == S_WAIT_B) || (state == S_WAIT_OP);

    uart_frame_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_frame_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .tc_c   (timer_tc_c)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_timeout  <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            state      <= state_nxt;
            o_alu_a    <= a_nxt;
            o_alu_b    <= b_nxt;
            o_alu_op   <= op_nxt;
            o_tx_data  <= tx_data_nxt;
            o_tx_start <= tx_start_nxt;
            o_busy     <= busy_nxt;
            o_timeout  <= timeout_nxt;
            o_overrun  <= overrun_nxt;
        end
    end

    // Next-state and next-output decode; a received byte wins over a coincident timeout
    always_comb begin
        state_nxt    = state;
        a_nxt        = o_alu_a;
        b_nxt        = o_alu_b;
        op_nxt       = o_alu_op;
        tx_data_nxt  = o_tx_data;
        tx_start_nxt = 1'b0;
        timeout_nxt  = 1'b0;
        overrun_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                if (i_rx_done) begin
                    a_nxt     = i_rx_data;
                    state_nxt = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (i_rx_done) begin
                    b_nxt     = i_rx_data;
                    state_nxt = S_WAIT_OP;
                end else if (timer_tc_c) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            S_WAIT_OP: begin
                if (i_rx_done) begin
                    op_nxt    = i_rx_data[OP_WIDTH-1:0];
                    state_nxt = S_EXEC;
                end else if (timer_tc_c) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            S_EXEC: begin
                tx_data_nxt = i_alu_result;
                overrun_nxt = i_rx_done;
                state_nxt   = S_SEND;
            end
            S_SEND: begin
                tx_start_nxt = 1'b1;
                overrun_nxt  = i_rx_done;
                state_nxt    = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                overrun_nxt = i_rx_done;
                if (i_tx_done) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Randomized self-checking bench for uart_alu_ctrl against a frame-level reference model.
module tb_uart_alu_ctrl;
    import uart_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned OW = 6;
    localparam int unsigned TO = 100;

    logic          clk;
    logic          reset;
    logic          i_rx_done;
    logic [DW-1:0] i_rx_data;
    logic          i_tx_done;
    logic          o_tx_start;
    logic [DW-1:0] o_tx_data;
    logic [DW-1:0] o_alu_a;
    logic [DW-1:0] o_alu_b;
    logic [OW-1:0] o_alu_op;
    logic [DW-1:0] i_alu_result;
    logic          o_busy;
    logic          o_timeout;
    logic          o_overrun;

    int errors = 0;
    int checks = 0;
    int start_pulses = 0;
    int exp_pulses = 0;

    // Reference frame state: what the operand registers should hold
    logic [DW-1:0] m_a, m_b;
    logic [OW-1:0] m_op;

    uart_alu_ctrl #(
        .DATA_WIDTH     (DW),
        .OP_WIDTH       (OW),
        .TIMEOUT_CYCLES (TO),
        .TO_W           (21)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_rx_done    (i_rx_done),
        .i_rx_data    (i_rx_data),
        .i_tx_done    (i_tx_done),
        .o_tx_start   (o_tx_start),
        .o_tx_data    (o_tx_data),
        .o_alu_a      (o_alu_a),
        .o_alu_b      (o_alu_b),
        .o_alu_op     (o_alu_op),
        .i_alu_result (i_alu_result),
        .o_busy       (o_busy),
        .o_timeout    (o_timeout),
        .o_overrun    (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: the environment the controller drives
    function automatic logic [DW-1:0] alu_ref(logic [DW-1:0] a, logic [DW-1:0] b, logic [OW-1:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            default: return a ^ b;
        endcase
    endfunction

    always_comb i_alu_result = alu_ref(o_alu_a, o_alu_b, o_alu_op);

    // Count every cycle in which the start strobe is high
    always @(posedge clk) if (o_tx_start === 1'b1) start_pulses++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [DW-1:0] d);
        i_rx_data = d;
        i_rx_done = 1'b1;
        step();
        i_rx_done = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) step();
    endtask

    // After the opcode byte: latency, result, optional overrun, then release with tx_done
    task automatic finish_frame(input logic [DW-1:0] exp, input bit ovr);
        chk("alu_a", o_alu_a, m_a);
        chk("alu_b", o_alu_b, m_b);
        chk("alu_op", o_alu_op, m_op);
        chk("start_c1", o_tx_start, 0);
        step();
        chk("start_c2", o_tx_start, 0);
        step();
        chk("start_c3", o_tx_start, 1);
        chk("tx_data", o_tx_data, exp);
        exp_pulses++;
        step();
        chk("start_c4", o_tx_start, 0);
        chk("busy_wait_tx", o_busy, 1);
        if (ovr) begin
            send_byte(8'hFF);
            chk("overrun_pulse", o_overrun, 1);
            step();
            chk("overrun_single", o_overrun, 0);
            chk("tx_data_hold", o_tx_data, exp);
            chk("alu_a_hold", o_alu_a, m_a);
        end
        gap($urandom_range(0, 4));
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        chk("busy_after_tx", o_busy, 0);
        chk("tx_data_after", o_tx_data, exp);
    endtask

    task automatic run_frame(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [DW-1:0] opb, input int gmax, input bit ovr);
        send_byte(a);
        m_a = a;
        gap($urandom_range(0, gmax));
        send_byte(b);
        m_b = b;
        gap($urandom_range(0, gmax));
        send_byte(opb);
        m_op = opb[OW-1:0];
        finish_frame(alu_ref(a, b, opb[OW-1:0]), ovr);
    endtask

    task automatic model_reset();
        m_a = '0;
        m_b = '0;
        m_op = '0;
    endtask

    function automatic logic [63:0] all_outs();
        return {30'd0, o_busy, o_tx_start, o_tx_data, o_alu_a, o_alu_b, o_alu_op, o_timeout, o_overrun};
    endfunction

    initial begin
        logic [DW-1:0] ops [4];
        logic [63:0]   acc;
        int            n;
        int            p0;

        ops[0] = {2'b00, OP_ADD};
        ops[1] = {2'b00, OP_SUB};
        ops[2] = {2'b00, OP_AND};
        ops[3] = {2'b00, OP_OR};
        reset = 1'b0;
        i_rx_done = 1'b0;
        i_rx_data = '0;
        i_tx_done = 1'b0;
        model_reset();
        gap(3);
        @(negedge clk) reset = 1'b1;

        // Quiet after reset
        acc = '0;
        repeat (100) begin
            step();
            acc = acc | all_outs();
        end
        chk("idle_outputs", acc, 0);
        chk("idle_no_start", start_pulses, 0);

        // Directed ADD frame
        run_frame(8'h05, 8'h03, 8'h20, 0, 1'b0);

        // Timeout in S_WAIT_B; stray tx_done there is ignored
        send_byte(8'h05);
        m_a = 8'h05;
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        chk("tx_done_ignored", o_busy, 1);
        n = 1;
        while (o_timeout !== 1'b1 && n < 3 * TO) begin
            step();
            n++;
        end
        chk("timeout_latency", n, TO);
        chk("timeout_idle", o_busy, 0);
        chk("timeout_keep_a", o_alu_a, m_a);
        chk("timeout_keep_b", o_alu_b, m_b);
        step();
        chk("timeout_single", o_timeout, 0);
        run_frame(8'h0A, 8'h01, 8'h22, 3, 1'b0);

        // Overrun during S_WAIT_TX, then fresh frame
        run_frame(8'h11, 8'h22, {2'b11, OP_OR}, 2, 1'b1);
        run_frame(8'h40, 8'h02, 8'h20, 2, 1'b0);

        // Byte arriving on the terminal-count cycle is taken as B
        send_byte(8'h33);
        m_a = 8'h33;
        acc = '0;
        repeat (TO - 1) begin
            step();
            acc = acc | 64'(o_timeout);
        end
        send_byte(8'h44);
        m_b = 8'h44;
        acc = acc | 64'(o_timeout);
        chk("tc_no_timeout", acc, 0);
        chk("tc_busy", o_busy, 1);
        step();
        chk("tc_no_timeout_late", o_timeout, 0);
        send_byte({2'b00, OP_SUB});
        m_op = OP_SUB;
        finish_frame(8'h33 - 8'h44, 1'b0);

        // Reset in S_WAIT_OP
        send_byte(8'h77);
        send_byte(8'h66);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("rst_wait_op_outs", all_outs(), 0);
        gap(2);
        @(negedge clk) reset = 1'b1;
        run_frame(8'h09, 8'h07, 8'h20, 2, 1'b0);

        // Reset in S_WAIT_TX right after the start pulse
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h20);
        gap(3);
        exp_pulses++;
        p0 = start_pulses;
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("rst_wait_tx_outs", all_outs(), 0);
        gap(3);
        @(negedge clk) reset = 1'b1;
        gap(3);
        chk("rst_no_start_glitch", start_pulses, p0);
        run_frame(8'hC8, 8'h64, {2'b10, OP_ADD}, 2, 1'b0);

        // Randomized frames
        for (int i = 0; i < 24; i++) begin
            logic [DW-1:0] opb;
            opb = ($urandom_range(0, 4) == 4) ? DW'($urandom) : ops[$urandom_range(0, 3)];
            run_frame(DW'($urandom), DW'($urandom), opb, 20, ($urandom_range(0, 3) == 0));
        end

        chk("total_start_pulses", start_pulses, exp_pulses);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
- Sequencer between the uart RX/TX pair and a combinational ALU.
- Collects three bytes from the receiver in order: operand A, operand B, opcode.
- Presents them to the ALU, latches the result and commands the transmitter to send it back.
- Sits at top level beside the uart instance; it is the only master of the TX start strobe.

Parameters:
- DATA_WIDTH, 8, width of data bytes, operands and result.
- OP_WIDTH, 6, width of opcode driven to the ALU (low bits of the opcode byte).
- TIMEOUT_CYCLES, 2_000_000, clk cycles allowed between bytes of one frame before abort.
- TO_W, 21, width of the timeout counter (must hold TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- i_rx_done  in  1  one-cycle pulse, received byte valid on i_rx_data
- i_rx_data  in  DATA_WIDTH  received byte
- i_tx_done  in  1  one-cycle pulse, transmitter finished a byte
- o_tx_start  out  1  one-cycle pulse, start transmitting o_tx_data
- o_tx_data  out  DATA_WIDTH  byte to transmit
- o_alu_a  out  DATA_WIDTH  operand A to ALU
- o_alu_b  out  DATA_WIDTH  operand B to ALU
- o_alu_op  out  OP_WIDTH  opcode to ALU
- i_alu_result  in  DATA_WIDTH  combinational ALU result
- o_busy  out  1  high in any state other than S_IDLE
- o_timeout  out  1  one-cycle pulse when a frame is aborted by timeout
- o_overrun  out  1  one-cycle pulse when a byte arrives while executing/sending and is dropped

Behaviour:
- Reset (reset=0, async): state S_IDLE; all outputs and registers 0; timeout counter 0.
- FSM states: S_IDLE, S_WAIT_B, S_WAIT_OP, S_EXEC, S_SEND, S_WAIT_TX. All outputs are registered.
- S_IDLE: on i_rx_done, latch i_rx_data into A and go to S_WAIT_B.
- S_WAIT_B: on i_rx_done, latch B and go to S_WAIT_OP.
- S_WAIT_OP: on i_rx_done, latch i_rx_data[OP_WIDTH-1:0] into OP and go to S_EXEC.
- Operand/opcode registers drive o_alu_a/b/op continuously; they hold their values until overwritten by the next frame.
- Timeout:
  - Counter clears on every state entry and on every i_rx_done.
  - Increments each cycle while in S_WAIT_B or S_WAIT_OP.
  - When it reaches TIMEOUT_CYCLES-1 with no i_rx_done that cycle: go to S_IDLE, pulse o_timeout, leave A/B/OP unchanged.
  - If i_rx_done coincides with the terminal count, the byte wins and there is no timeout.
- S_EXEC: one cycle. Latch i_alu_result into o_tx_data, go to S_SEND.
- S_SEND: one cycle. Assert o_tx_start=1, go to S_WAIT_TX.
  - Latency: the byte completing the opcode (cycle 0) gives o_tx_start high on cycle 3 (WAIT_OP → EXEC → SEND → pulse registered).
- S_WAIT_TX: hold o_tx_data stable; on i_tx_done go to S_IDLE. No timeout here.
- i_rx_done while in S_EXEC, S_SEND or S_WAIT_TX: byte dropped, o_overrun pulses the next cycle, state unaffected.
- i_tx_done outside S_WAIT_TX: ignored.
- Reset asserted mid-frame or mid-transmit: immediate return to S_IDLE with all outputs cleared. o_tx_start is never left high.
- Illegal state encodings recover to S_IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings for this FSM (3-bit localparams S_IDLE..S_WAIT_TX);
  - default DATA_WIDTH;
  - opcode constants used by the bench (ADD=6'b100000, SUB=6'b100010, AND=6'b100100, OR=6'b100101).
- One natural sub-module: uart_frame_timer (load/clear, enable, terminal-count pulse), parameterised by TIMEOUT_CYCLES and TO_W.

Test Plan:
- Reset release, no stimulus for 100 cycles → o_busy=0, o_tx_start never asserted, all outputs 0.
- Receive 0x05, 0x03, 0x20; ALU model returns A+B → o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20; o_tx_start pulses once, 3 cycles after the third rx_done, with o_tx_data=0x08; return to S_IDLE on i_tx_done.
- Receive 0x05, then nothing, TIMEOUT_CYCLES=100 → o_timeout pulses exactly 100 cycles after entering S_WAIT_B; next frame 0x0A, 0x01, 0x22 (SUB) yields o_tx_data=0x09.
- Complete a frame, then pulse i_rx_done with 0xFF during S_WAIT_TX → o_overrun pulses once; o_tx_data unchanged; after i_tx_done the next frame starts fresh with A taken from its first byte.
- Assert reset in S_WAIT_OP and again while in S_WAIT_TX → all outputs 0 asynchronously, no o_tx_start glitch, next full frame processed correctly.
- i_rx_done on the exact terminal-count cycle in S_WAIT_B → byte accepted as B, no o_timeout.
